// File: rtl/fft_pkg.sv
// Shared definitions for the FFT bank arbiter: sizes, requester ids, FSM states.
package fft_pkg;

  localparam int unsigned WORDSIZE   = 16;
  localparam int unsigned ADDRSIZE   = 3;
  localparam int unsigned NUMSAMPLES = 32;
  localparam int unsigned NUMBANKS   = 4;
  localparam int unsigned NUMREQ     = 3;

  localparam logic [1:0] REQ_LOADER = 2'd0;
  localparam logic [1:0] REQ_STAGE  = 2'd1;
  localparam logic [1:0] REQ_OUTPUT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // One-hot requester vector to index; an empty vector maps to the loader.
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    if (oh[2])      return REQ_OUTPUT;
    else if (oh[1]) return REQ_STAGE;
    else            return REQ_LOADER;
  endfunction

endpackage

// File: rtl/fft_rr_pick.sv
// Combinational 3-way round-robin selector: search starts just after the last winner.
module fft_rr_pick (
  input  logic [2:0] req_i,
  input  logic [1:0] last_winner_i,
  output logic [2:0] winner_o
);

  int unsigned idx;

  // First requesting index in the order last_winner+1, +2, +3 (mod 3).
  always_comb begin
    winner_o = '0;
    idx      = 0;
    for (int unsigned k = 1; k <= 3; k++) begin
      idx = (int'(last_winner_i) + k) % 3;
      if ((winner_o == '0) && req_i[idx]) begin
        winner_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_bank_arbiter.sv
// Arbitrates three requesters (loader, stage engine, output reader) onto four RAM banks.
module fft_bank_arbiter #(
  parameter int unsigned WORDSIZE = 16,
  parameter int unsigned ADDRSIZE = 3,
  parameter int unsigned MAXBURST = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              req,
  input  logic [2:0]              last,
  input  logic [3*4*ADDRSIZE-1:0] rd_addr_in,
  input  logic [3*4*ADDRSIZE-1:0] wr_addr_in,
  input  logic [3*4-1:0]          rd_en_in,
  input  logic [3*4-1:0]          wr_en_in,
  output logic [2:0]              gnt,
  output logic [4*ADDRSIZE-1:0]   rd_addr_out,
  output logic [4*ADDRSIZE-1:0]   wr_addr_out,
  output logic [3:0]              rd_en_out,
  output logic [3:0]              wr_en_out,
  output logic [3:0]              cs_out,
  output logic                    busy,
  output logic                    timeout
);

  import fft_pkg::*;

  localparam int unsigned BANK_W = NUMBANKS * ADDRSIZE;
  localparam int unsigned CNT_W  = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXBURST - 1);

  if (MAXBURST < 2) begin : g_bad_maxburst
    $error("MAXBURST must be at least 2");
  end
  if (WORDSIZE == 0) begin : g_bad_wordsize
    $error("WORDSIZE must be non-zero");
  end

  arb_state_e          state_q;
  logic [2:0]          gnt_q;
  logic [1:0]          last_winner_q;
  logic [CNT_W-1:0]    burst_q;
  logic [BANK_W-1:0]   rd_addr_q, wr_addr_q;
  logic [3:0]          rd_en_q, wr_en_q, cs_q;
  logic                timeout_q;

  logic [2:0]          pick_oh;
  logic [1:0]          gnt_idx;
  logic                sel_req, sel_last;
  logic [BANK_W-1:0]   sel_rd_addr, sel_wr_addr;
  logic [3:0]          sel_rd_en, sel_wr_en;

  fft_rr_pick u_pick (
    .req_i         (req),
    .last_winner_i (last_winner_q),
    .winner_o      (pick_oh)
  );

  // Mux out the currently granted requester's request and bank slices.
  always_comb begin
    gnt_idx     = onehot_to_idx(gnt_q);
    sel_req     = req[gnt_idx];
    sel_last    = last[gnt_idx];
    sel_rd_addr = rd_addr_in[gnt_idx*BANK_W +: BANK_W];
    sel_wr_addr = wr_addr_in[gnt_idx*BANK_W +: BANK_W];
    sel_rd_en   = rd_en_in[gnt_idx*NUMBANKS +: NUMBANKS];
    sel_wr_en   = wr_en_in[gnt_idx*NUMBANKS +: NUMBANKS];
  end

  // Arbitration FSM with registered grant, bank outputs and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      last_winner_q <= REQ_OUTPUT;
      burst_q       <= '0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      rd_en_q       <= '0;
      wr_en_q       <= '0;
      cs_q          <= '0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rd_en_q <= '0;
          wr_en_q <= '0;
          cs_q    <= '0;
          if (|req) begin
            state_q       <= ST_GRANT;
            gnt_q         <= pick_oh;
            last_winner_q <= onehot_to_idx(pick_oh);
            burst_q       <= '0;
          end
        end
        ST_GRANT: begin
          burst_q <= burst_q + 1'b1;
          if (sel_req) begin
            rd_addr_q <= sel_rd_addr;
            wr_addr_q <= sel_wr_addr;
            rd_en_q   <= sel_rd_en;
            wr_en_q   <= sel_wr_en;
            cs_q      <= sel_rd_en | sel_wr_en;
            if (sel_last) begin
              state_q <= ST_DRAIN;
              gnt_q   <= '0;
            end else if (burst_q == CNT_MAX) begin
              state_q   <= ST_DRAIN;
              gnt_q     <= '0;
              timeout_q <= 1'b1;
            end
          end else begin
            // Dropped request: this cycle's beat is discarded, addresses hold.
            rd_en_q <= '0;
            wr_en_q <= '0;
            cs_q    <= '0;
            state_q <= ST_DRAIN;
            gnt_q   <= '0;
          end
        end
        ST_DRAIN: begin
          rd_en_q <= '0;
          wr_en_q <= '0;
          cs_q    <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign rd_addr_out = rd_addr_q;
  assign wr_addr_out = wr_addr_q;
  assign rd_en_out   = rd_en_q;
  assign wr_en_out   = wr_en_q;
  assign cs_out      = cs_q;
  assign timeout     = timeout_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fft_bank_arbiter.sv
// Self-checking bench for fft_bank_arbiter against a transaction-level reference model.
module tb_fft_bank_arbiter;

  localparam int A  = 3;
  localparam int MB = 64;
  localparam int AW = 3*4*A;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req, last;
  logic [AW-1:0] rd_addr_in, wr_addr_in;
  logic [11:0]   rd_en_in, wr_en_in;
  logic [2:0]    gnt;
  logic [4*A-1:0] rd_addr_out, wr_addr_out;
  logic [3:0]    rd_en_out, wr_en_out, cs_out;
  logic          busy, timeout;

  always #5 clk = ~clk;

  fft_bank_arbiter #(.WORDSIZE(16), .ADDRSIZE(A), .MAXBURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .rd_addr_in(rd_addr_in), .wr_addr_in(wr_addr_in),
    .rd_en_in(rd_en_in), .wr_en_in(wr_en_in),
    .gnt(gnt), .rd_addr_out(rd_addr_out), .wr_addr_out(wr_addr_out),
    .rd_en_out(rd_en_out), .wr_en_out(wr_en_out), .cs_out(cs_out),
    .busy(busy), .timeout(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: who owns the banks, how many beats they have moved,
  // and whether the one-cycle gap after a release is pending.
  int             m_owner = -1;
  int             m_prev  = 2;
  int             m_beats = 0;
  bit             m_gap   = 1'b0;
  logic [2:0]     e_gnt;
  logic [4*A-1:0] e_rda, e_wra;
  logic [3:0]     e_rden, e_wren, e_cs;
  logic           e_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_prev = 2; m_beats = 0; m_gap = 1'b0;
      e_gnt = '0; e_rda = '0; e_wra = '0; e_rden = '0; e_wren = '0; e_cs = '0; e_to = 1'b0;
    end else begin
      e_to = 1'b0;
      if (m_owner >= 0) begin
        if (req[m_owner]) begin
          e_rda  = rd_addr_in[m_owner*4*A +: 4*A];
          e_wra  = wr_addr_in[m_owner*4*A +: 4*A];
          e_rden = rd_en_in[m_owner*4 +: 4];
          e_wren = wr_en_in[m_owner*4 +: 4];
          e_cs   = e_rden | e_wren;
          m_beats++;
          if (last[m_owner] || m_beats == MB) begin
            e_to    = !last[m_owner];
            m_owner = -1; m_gap = 1'b1; e_gnt = '0;
          end
        end else begin
          e_rden = '0; e_wren = '0; e_cs = '0;
          m_owner = -1; m_gap = 1'b1; e_gnt = '0;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
        e_rden = '0; e_wren = '0; e_cs = '0;
      end else begin
        e_rden = '0; e_wren = '0; e_cs = '0;
        for (int k = 1; k <= 3; k++) begin
          if (m_owner < 0 && req[(m_prev + k) % 3]) m_owner = (m_prev + k) % 3;
        end
        if (m_owner >= 0) begin
          m_prev  = m_owner;
          m_beats = 0;
          e_gnt   = 3'b001 << m_owner;
        end
      end
    end
  end

  task automatic compare_all();
    check_eq("gnt",     gnt,         e_gnt);
    check_eq("rd_addr", rd_addr_out, e_rda);
    check_eq("wr_addr", wr_addr_out, e_wra);
    check_eq("rd_en",   rd_en_out,   e_rden);
    check_eq("wr_en",   wr_en_out,   e_wren);
    check_eq("cs",      cs_out,      e_cs);
    check_eq("busy",    busy,        (m_owner >= 0) || m_gap);
    check_eq("timeout", timeout,     e_to);
  endtask

  bit chk_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (chk_en) compare_all();
  end

  function automatic logic rbit(input int unsigned pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic rand_data();
    rd_addr_in = AW'({$urandom(), $urandom()});
    wr_addr_in = AW'({$urandom(), $urandom()});
    rd_en_in   = 12'($urandom());
    wr_en_in   = 12'($urandom());
  endtask

  task automatic wait_gnt(input int r);
    int i = 0;
    while (!gnt[r] && i < 200) begin
      @(negedge clk);
      i++;
    end
    check_eq($sformatf("gnt%0d_wait", r), gnt[r], 1'b1);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    check_eq("idle_wait", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_gnt"},  gnt, 3'b000);
    check_eq({pfx, "_busy"}, busy, 1'b0);
    check_eq({pfx, "_to"},   timeout, 1'b0);
    check_eq({pfx, "_en"},   {rd_en_out, wr_en_out, cs_out}, 12'h000);
    check_eq({pfx, "_addr"}, {rd_addr_out, wr_addr_out}, '0);
  endtask

  initial begin
    logic [2:0]   order [3];
    logic [2:0]   prevg;
    logic [A-1:0] bv;
    int           ng, nto, nwr;

    req = '0; last = '0; rd_addr_in = '0; wr_addr_in = '0; rd_en_in = '0; wr_en_in = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests after reset: loader, stage, reader in turn.
    req = 3'b111;
    ng = 0; prevg = '0;
    for (int i = 0; i < 300 && ng < 3; i++) begin
      rand_data();
      last = {rbit(30), rbit(30), rbit(30)};
      @(negedge clk);
      if (gnt != '0 && prevg == '0) begin
        order[ng] = gnt;
        ng++;
      end
      prevg = gnt;
    end
    check_eq("rr_count", ng, 3);
    if (ng == 3) begin
      check_eq("rr_first",  order[0], 3'b001);
      check_eq("rr_second", order[1], 3'b010);
      check_eq("rr_third",  order[2], 3'b100);
    end
    req = '0; last = '0;
    wait_idle();

    // Loader burst of eight write beats, addresses 0..7.
    rd_addr_in = '0; wr_addr_in = '0; rd_en_in = '0; wr_en_in = 12'h00F;
    req = 3'b001;
    wait_gnt(0);
    nwr = 0;
    for (int b = 0; b < 8; b++) begin
      bv = A'(b);
      wr_addr_in = '0;
      wr_addr_in[4*A-1:0] = {4{bv}};
      last = (b == 7) ? 3'b001 : 3'b000;
      @(negedge clk);
      check_eq("wr_addr_seq", wr_addr_out, {4{bv}});
      if (wr_en_out == 4'hF) nwr++;
    end
    req = '0; last = '0; wr_en_in = '0;
    check_eq("burst_wr_beats", nwr, 8);
    check_eq("burst_drain_busy", busy, 1'b1);
    @(negedge clk);
    check_eq("burst_idle_busy", busy, 1'b0);
    check_eq("burst_idle_wr_en", wr_en_out, 4'h0);

    // Stage engine holds the grant without last: forced release, reader next.
    req = 3'b110; last = '0;
    ng = 0; nto = 0; prevg = '0;
    order[0] = '0; order[1] = '0;
    for (int i = 0; i < 70; i++) begin
      rand_data();
      @(negedge clk);
      if (timeout) nto++;
      if (gnt != '0 && prevg == '0 && ng < 2) begin
        order[ng] = gnt;
        ng++;
      end
      prevg = gnt;
    end
    check_eq("to_pulses",   nto, 1);
    check_eq("to_first",    order[0], 3'b010);
    check_eq("to_next_gnt", order[1], 3'b100);
    req = '0;
    wait_idle();

    // Output reader drops its request on beat three.
    rd_en_in = 12'hF00; wr_en_in = '0;
    req = 3'b100;
    wait_gnt(2);
    for (int b = 0; b < 2; b++) begin
      rd_addr_in = AW'({$urandom(), $urandom()});
      @(negedge clk);
      check_eq("reader_beat_en", rd_en_out, 4'hF);
    end
    req = '0;
    @(negedge clk);
    check_eq("rd_en_drop",   rd_en_out, 4'h0);
    check_eq("drop_gnt",     gnt, 3'b000);
    check_eq("drop_busy",    busy, 1'b1);
    @(negedge clk);
    check_eq("reader_idle",  busy, 1'b0);

    // Asynchronous reset in the middle of a stage-engine grant.
    req = 3'b110;
    wait_gnt(1);
    repeat (3) begin
      rand_data();
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_en",  {rd_en_out, wr_en_out, cs_out}, 12'h000);
    check_eq("post_rst_gnt", gnt, 3'b000);
    req = 3'b111;
    wait_gnt(0);
    check_eq("post_rst_winner", gnt, 3'b001);
    req = '0;
    wait_idle();

    // Fully random traffic; non-granted requesters toggle freely.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      req  = {rbit(75), rbit(75), rbit(75)};
      last = {rbit(20), rbit(20), rbit(20)};
      @(negedge clk);
    end
    req = '0; last = '0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bank_arbiter.md
FFT_BANK_ARBITER -- requirements
Module: fft_bank_arbiter

Interface
REQ-001 Parameter WORDSIZE, default 16, sample word width (passed through to the package only; no data ports on this block).
REQ-002 Parameter ADDRSIZE, default 3, per-bank address width (NUMSAMPLES/4 = 8 words).
REQ-003 Parameter MAXBURST, default 64, maximum cycles one grant is held.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  3  per-requester request; index 0 = RAM loader, 1 = stage engine, 2 = output reader.
REQ-007 last  in  3  per-requester final beat of the current burst.
REQ-008 rd_addr_in  in  3*4*ADDRSIZE  read address per requester per bank; slice [r][b].
REQ-009 wr_addr_in  in  3*4*ADDRSIZE  write address per requester per bank.
REQ-010 rd_en_in  in  3*4  read enable per requester per bank.
REQ-011 wr_en_in  in  3*4  write enable per requester per bank.
REQ-012 gnt  out  3  one-hot grant, registered.
REQ-013 rd_addr_out, wr_addr_out  out  4*ADDRSIZE each  per-bank addresses to banks 0-3, registered.
REQ-014 rd_en_out, wr_en_out, cs_out  out  4 each  per-bank enables and chip selects, registered.
REQ-015 busy  out  1  high whenever any grant is active or a drain cycle is in progress.
REQ-016 timeout  out  1  one-cycle pulse on forced grant release.

Function
REQ-017 FSM states: IDLE, GRANT, DRAIN.
REQ-018 IDLE with any req bit set: select the winner, move to GRANT; gnt bit set on the next edge.
REQ-019 Winner selection is round-robin: search starts at index (last_winner+1) mod 3; last_winner resets to 2, so the loader wins first.
REQ-020 GRANT: the granted requester's inputs sampled at edge k appear on bank outputs after edge k+1; cs_out = rd_en_in|wr_en_in of the granted requester.
REQ-021 GRANT exits to DRAIN when the granted requester's last=1 with req=1; that beat is still forwarded.
REQ-022 GRANT exits to DRAIN when the granted requester drops req; that cycle's inputs are not forwarded (enables 0).
REQ-023 Burst counter: cleared on entry to GRANT, incremented each GRANT cycle; on reaching MAXBURST-1, force DRAIN, pulse timeout for one cycle.
REQ-024 DRAIN: lasts exactly 1 cycle; gnt=0, all enables and cs 0, addresses hold; then IDLE; a new grant is never issued in DRAIN.
REQ-025 Outside GRANT: rd_en_out, wr_en_out, cs_out all 0; gnt all 0.
REQ-026 Non-granted requesters' inputs are ignored; req changes of non-granted requesters never disturb an active grant.
REQ-027 last asserted with req=0 is ignored.
REQ-028 Address slices are forwarded unchanged; no arithmetic on addresses.
REQ-029 busy = (state != IDLE).

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, gnt 0, all bank outputs and addresses 0, busy 0, timeout 0, burst counter 0, last_winner 2.
REQ-031 Reset mid-burst aborts the grant; no beat is forwarded after deassertion until a new arbitration.

Structure
REQ-032 Shared package fft_pkg holds WORDSIZE, ADDRSIZE, NUMSAMPLES, NUMBANKS=4, requester index constants and the FSM state encoding.
REQ-033 One sub-module, fft_rr_pick: combinational 3-way round-robin selector (req, last_winner -> one-hot winner).

Verification
REQ-034 Reset release, req=3'b111 simultaneously -> gnt 001, then 010, then 100 on successive arbitrations, each separated by one DRAIN cycle.
REQ-035 Loader burst of 8 beats, wr_en_in[0]=4'hF, addr 0..7, last on beat 8 -> wr_addr_out 0..7 one cycle late, wr_en_out 4'hF for 8 cycles, then 0, busy low two cycles after last.
REQ-036 Stage engine holds req with no last for 70 cycles -> timeout pulses once at burst cycle 63, gnt drops, next winner is output reader if requesting.
REQ-037 Output reader granted, drops req at beat 3 -> beat 3 not forwarded, rd_en_out 0 that cycle, DRAIN, IDLE.
REQ-038 rst_n pulsed low mid-grant -> all outputs 0 immediately (before next edge), next arbitration grants loader first.
REQ-039 Non-granted requester toggles req/last/enables during a grant -> bank outputs match only granted requester.
